// File: rtl/amm_arb_pkg.sv
// rtl/amm_arb_pkg.sv - shared types and grant-select helpers for amm_arbiter
package amm_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_e;

  // Widest supported master count; select helpers work on vectors this wide.
  localparam int MAX_M = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requesting index strictly after ptr, wrapping; ptr itself has lowest priority.
  function automatic logic [2:0] rr_select(input logic [MAX_M-1:0] req, input int n,
                                           input logic [2:0] ptr);
    logic [2:0] sel;
    int idx;
    sel = ptr;
    for (int i = MAX_M; i >= 1; i--) begin
      if (i <= n) begin
        idx = (int'(ptr) + i) % n;
        if (req[idx[2:0]]) sel = idx[2:0];
      end
    end
    return sel;
  endfunction

  // Lowest requesting index wins.
  function automatic logic [2:0] fixed_select(input logic [MAX_M-1:0] req, input int n);
    logic [2:0] sel;
    sel = 3'd0;
    for (int i = MAX_M - 1; i >= 0; i--) begin
      if (i < n && req[i]) sel = 3'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/amm_arb_id_fifo.sv
// rtl/amm_arb_id_fifo.sv - synchronous FIFO holding master IDs of outstanding reads
module amm_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy update; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/amm_arbiter.sv
// rtl/amm_arbiter.sv - round-robin Avalon-MM arbiter; define AMM_ARB_FIXED_PRIO_EN for fixed priority
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int NUM_M    = 4,
  parameter int A_W      = 8,
  parameter int D_W      = 64,
  parameter int MAX_PEND = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_M*A_W-1:0]   m_address_i,
  input  logic [NUM_M-1:0]       m_read_i,
  input  logic [NUM_M-1:0]       m_write_i,
  input  logic [NUM_M*D_W-1:0]   m_writedata_i,
  input  logic [NUM_M*D_W/8-1:0] m_byteenable_i,
  output logic [NUM_M-1:0]       m_waitrequest_o,
  output logic [D_W-1:0]         m_readdata_o,
  output logic [NUM_M-1:0]       m_readdatavalid_o,
  output logic [A_W-1:0]         s_address_o,
  output logic                   s_read_o,
  output logic                   s_write_o,
  output logic [D_W-1:0]         s_writedata_o,
  output logic [D_W/8-1:0]       s_byteenable_o,
  input  logic                   s_waitrequest_i,
  input  logic [D_W-1:0]         s_readdata_i,
  input  logic                   s_readdatavalid_i,
  output logic                   unexp_rdv_o
);
  localparam int ID_W = id_w(NUM_M);
  localparam int BE_W = D_W / 8;

  state_e          state_q, state_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic            unexp_q, unexp_d;
  logic [NUM_M-1:0] req;
  logic [MAX_M-1:0] req_ext;
  logic [2:0]      sel_full;
  logic            grant_act, cmd_wr, cmd_rd, rd_block, accept;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ID_W-1:0] fifo_head;

  assign req       = m_read_i | m_write_i;
  assign req_ext   = MAX_M'(req);
  assign grant_act = rst_i & (state_q == GRANT);
  assign cmd_wr    = m_write_i[gnt_q];
  assign cmd_rd    = m_read_i[gnt_q] & ~cmd_wr;
  assign rd_block  = cmd_rd & fifo_full;

  assign s_address_o    = m_address_i[gnt_q*A_W +: A_W];
  assign s_writedata_o  = m_writedata_i[gnt_q*D_W +: D_W];
  assign s_byteenable_o = m_byteenable_i[gnt_q*BE_W +: BE_W];
  assign s_write_o      = grant_act & cmd_wr;
  assign s_read_o       = grant_act & cmd_rd & ~rd_block;
  assign accept         = (s_read_o | s_write_o) & ~s_waitrequest_i;

  assign m_readdata_o = s_readdata_i;
  assign unexp_rdv_o  = unexp_q;
  assign fifo_push    = s_read_o & ~s_waitrequest_i;
  assign fifo_pop     = rst_i & s_readdatavalid_i;

`ifdef AMM_ARB_FIXED_PRIO_EN
  assign sel_full = fixed_select(req_ext, NUM_M);
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign sel_full = rr_select(req_ext, NUM_M, 3'(ptr_q));
  assign ptr_d    = accept ? gnt_q : ptr_q;

  // Round-robin pointer: last accepted master, reset so master 0 wins first.
  always_ff @(posedge clk_i) begin
    if (!rst_i) ptr_q <= ID_W'(NUM_M - 1);
    else        ptr_q <= ptr_d;
  end
`endif

  amm_arb_id_fifo #(.DEPTH(MAX_PEND), .W(ID_W)) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (gnt_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // State, grant and sticky unexpected-readdatavalid registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      unexp_q <= unexp_d;
    end
  end

  // Next state: arbitrate in IDLE, leave GRANT on acceptance or request withdrawal.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unexp_d = unexp_q | (s_readdatavalid_i & fifo_empty);
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = sel_full[ID_W-1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_q] || accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Master-side handshake: only the granted master can see waitrequest low.
  always_comb begin
    m_waitrequest_o = '1;
    if (grant_act) m_waitrequest_o[gnt_q] = s_waitrequest_i | rd_block;
  end

  // Route each returning beat to the master at the FIFO head; orphan beats are dropped.
  always_comb begin
    m_readdatavalid_o = '0;
    if (rst_i && s_readdatavalid_i && !fifo_empty) m_readdatavalid_o[fifo_head] = 1'b1;
  end

endmodule
